// File: rtl/area_test_pkg.sv
`timescale 1ns/1ps
// area_test_pkg
//   Shared constants and the per-cell seed helper for area_test_core.
//   TAPS_DEFAULT : Galois feedback mask x^32+x^22+x^2+x+1 (maximal length)
//   SEED_BASE    : LFSR seed of cell 0
//   SEED_STEP    : seed increment between neighbouring cells
package area_test_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned NUM_CELLS = 8;

  localparam logic [WIDTH-1:0] TAPS_DEFAULT = 32'h80200003;
  localparam logic [WIDTH-1:0] SEED_BASE    = 32'h00000001;
  localparam logic [WIDTH-1:0] SEED_STEP    = 32'h01010101;

  // seed = base + idx*step, modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] seed_of(
    input int unsigned      idx,
    input logic [WIDTH-1:0] base,
    input logic [WIDTH-1:0] step
  );
    logic [WIDTH-1:0] idx_w;
    idx_w = WIDTH'(idx);
    return base + (idx_w * step);
  endfunction

endpackage

// File: rtl/area_test_core_cell.sv
`timescale 1ns/1ps
// area_cell
//   One area-exercise cell: a 32-bit Galois LFSR feeds a wrapping 32-bit
//   accumulator; led is the registered XOR-reduction of the accumulator.
//   Ports:
//     CLK   : rising-edge clock
//     RST_N : asynchronous active-low reset (lfsr=SEED, acc=0, led=0)
//     led   : registered parity of the accumulator (one edge behind acc)
module area_cell
  import area_test_pkg::*;
#(
  parameter logic [WIDTH-1:0] SEED = SEED_BASE,
  parameter logic [WIDTH-1:0] TAPS = TAPS_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  output logic led
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] acc_q,  acc_d;
  logic             led_q,  led_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    acc_d  = acc_q + lfsr_q;   // carry out discarded
    led_d  = ^acc_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_q <= SEED;
      acc_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      acc_q  <= acc_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/area_test_core.sv
`timescale 1ns/1ps
// area_test_core
//   Synthesis area exercise for the Alhambra-II: eight independent LFSR +
//   accumulator cells, each driving one LED with its registered parity.
//   Ports:
//     CLK        : system clock, rising-edge active
//     RST_N      : asynchronous active-low reset
//     LED0..LED7 : LEDi = registered accumulator parity of cell i
module area_test_core
  import area_test_pkg::*;
#(
  parameter logic [WIDTH-1:0] TAPS      = TAPS_DEFAULT,
  parameter logic [WIDTH-1:0] SEED_BASE = area_test_pkg::SEED_BASE,
  parameter logic [WIDTH-1:0] SEED_STEP = area_test_pkg::SEED_STEP
) (
  input  logic CLK,
  input  logic RST_N,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  logic [NUM_CELLS-1:0] led_w;

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
    area_cell #(
      .SEED (seed_of(g, SEED_BASE, SEED_STEP)),
      .TAPS (TAPS)
    ) u_cell (
      .CLK   (CLK),
      .RST_N (RST_N),
      .led   (led_w[g])
    );
  end

  assign LED0 = led_w[0];
  assign LED1 = led_w[1];
  assign LED2 = led_w[2];
  assign LED3 = led_w[3];
  assign LED4 = led_w[4];
  assign LED5 = led_w[5];
  assign LED6 = led_w[6];
  assign LED7 = led_w[7];

endmodule

// File: tb/tb_area_test_core.sv
`timescale 1ns/1ps
module tb_area_test_core;

  localparam logic [31:0] M_TAPS = 32'h80200003;
  localparam int unsigned RUN1   = 10000;
  localparam int unsigned REC    = 600;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;

  always #10 CLK = ~CLK;

  area_test_core dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .LED0  (LED0),
    .LED1  (LED1),
    .LED2  (LED2),
    .LED3  (LED3),
    .LED4  (LED4),
    .LED5  (LED5),
    .LED6  (LED6),
    .LED7  (LED7)
  );

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  // internal state monitors
  logic [31:0] lfsr_mon [8];
  logic [31:0] acc_mon  [8];
  for (genvar g = 0; g < 8; g++) begin : g_mon
    assign lfsr_mon[g] = dut.g_cell[g].u_cell.lfsr_q;
    assign acc_mon[g]  = dut.g_cell[g].u_cell.acc_q;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [31:0] m_lfsr [8];
  logic [31:0] m_acc  [8];
  logic [7:0]  m_led;
  logic [7:0]  sb_q [$];
  logic [7:0]  ref_seq [REC];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_lfsr[i] = 32'h00000001 + i * 32'h01010101;
      m_acc[i]  = '0;
    end
    m_led = '0;
    sb_q.delete();
  endtask

  task automatic model_step();
    logic [31:0] nl;
    logic [31:0] na;
    for (int i = 0; i < 8; i++) begin
      nl = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? M_TAPS : 32'h0);
      na = m_acc[i] + m_lfsr[i];
      m_led[i]  = ^m_acc[i];
      m_lfsr[i] = nl;
      m_acc[i]  = na;
    end
  endtask

  // One clock edge: model advances, expectation queued, DUT sampled on negedge.
  task automatic step_cycle(output logic [7:0] obs);
    logic [7:0] exp_led;
    logic [32:0] sum0;
    bit wrapped;
    @(posedge CLK);
    sum0    = {1'b0, m_acc[0]} + {1'b0, m_lfsr[0]};
    wrapped = sum0[32];
    model_step();
    sb_q.push_back(m_led);
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      exp_led = '0;
    end else begin
      exp_led = sb_q.pop_front();
    end
    check("led", {24'h0, leds}, {24'h0, exp_led});
    for (int i = 0; i < 8; i++) begin
      check("lfsr", lfsr_mon[i], m_lfsr[i]);
      check("lfsr_nz", {31'h0, lfsr_mon[i] != 32'h0}, 32'd1);
    end
    if (wrapped) check("acc0_wrap", acc_mon[0], m_acc[0]);
    obs = leds;
  endtask

  task automatic async_reset_and_release();
    #5 RST_N = 1'b0;
    #1;
    check("async_rst_led", {24'h0, leds}, 32'h0);
    check("async_rst_acc0", acc_mon[0], 32'h0);
    check("async_rst_lfsr7", lfsr_mon[7], 32'h07070708);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic rerun(input int unsigned n);
    logic [7:0] obs;
    for (int unsigned c = 0; c < n; c++) begin
      step_cycle(obs);
      check("rerun_seq", {24'h0, obs}, {24'h0, ref_seq[c]});
    end
  endtask

  initial begin
    logic [7:0]  obs;
    logic [7:0]  prev;
    int unsigned toggles [8];

    model_reset();
    RST_N = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("reset_led", {24'h0, leds}, 32'h0);
    end
    check("reset_lfsr0", lfsr_mon[0], 32'h00000001);
    check("reset_lfsr7", lfsr_mon[7], 32'h07070708);
    RST_N = 1'b1;

    // first edges after release
    step_cycle(obs);
    check("edge1_led", {24'h0, obs}, 32'h0);
    check("edge1_lfsr0", lfsr_mon[0], 32'h80200003);
    ref_seq[0] = obs;
    step_cycle(obs);
    check("edge2_led", {24'h0, obs}, 32'h5D);
    check("edge2_acc0", acc_mon[0], 32'h80200004);
    ref_seq[1] = obs;
    step_cycle(obs);
    check("edge3_led0", {31'h0, obs[0]}, 32'd1);
    ref_seq[2] = obs;

    for (int i = 0; i < 8; i++) toggles[i] = 0;
    prev = obs;
    for (int unsigned c = 3; c < RUN1; c++) begin
      step_cycle(obs);
      if (c < REC) ref_seq[c] = obs;
      for (int i = 0; i < 8; i++) if (obs[i] != prev[i]) toggles[i]++;
      prev = obs;
    end
    for (int i = 0; i < 8; i++)
      check($sformatf("toggles%0d_ge100(cnt=%0d)", i, toggles[i]),
            {31'h0, toggles[i] >= 100}, 32'd1);

    // mid-run reset, replay, then reset again after 500 cycles and replay
    async_reset_and_release();
    rerun(500);
    async_reset_and_release();
    rerun(REC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/area_test_core.md
Name: area_test_core

Overview:
- Synthesis area/utilisation exercise block for the Alhambra-II board.
- Eight independent cells each hold a 32-bit Galois LFSR feeding a 32-bit accumulator; each cell drives one LED with the registered parity of its accumulator.
- Top-level leaf with no data inputs; produces continuously changing, deterministic LED patterns from reset.

Parameters:
- TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1), maximal length.
- SEED_BASE, 32'h00000001, LFSR seed of cell 0.
- SEED_STEP, 32'h01010101, seed increment per cell: seed_i = SEED_BASE + i*SEED_STEP, modulo 2^32.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST_N  input  1  asynchronous active-low reset.
- LED0..LED7  output  1 each  LEDi = registered parity bit of cell i.

Behaviour:
- Clocking and reset:
  - One clock, one clock domain.
  - RST_N low asynchronously forces, for every cell i: lfsr_i = seed_i, acc_i = 0, LEDi = 0.
  - Reset is held while RST_N is low. Release is sampled at the next rising CLK edge.
- Per rising CLK edge with RST_N high, for each cell i, all updates are simultaneous and use pre-edge values:
  - lfsr_i <= (lfsr_i >> 1) ^ (lfsr_i[0] ? TAPS : 0)
  - acc_i <= acc_i + lfsr_i, 32-bit, carry out discarded (wraps modulo 2^32)
  - LEDi <= XOR-reduction of acc_i
- Latency:
  - LEDi reflects the accumulator as it stood one edge earlier.
  - Edge 1 after reset release: acc_i = seed_i, LEDs still 0.
  - Edge 2: LEDs = parity(seed_i).
- Invariants:
  - lfsr_i is never 0, because seeds are nonzero and the polynomial is maximal. The period is 2^32-1.
  - No enable and no stall: all cells advance every cycle.
- Outputs are driven directly from flops; there are no combinational paths to the LEDs.
- Reset mid-run: all state returns to the reset values immediately. The sequence after release is identical to the first run.
- Keep logic: each cell's state must influence an output, so synthesis cannot prune adders or LFSRs.

Decomposition:
- Shared package area_test_pkg:
  - TAPS default.
  - Seed base and step constants.
  - NUM_CELLS = 8.
  - WIDTH = 32.
  - Seed function seed_of(i).
- One sub-module: area_cell.
  - Parameters: SEED, TAPS.
  - Ports: CLK, RST_N, led.
  - Contains the LFSR, the accumulator and the parity flop.
  - Instantiated 8 times by a generate loop in area_test_core.

Test Plan:
- Reset: hold RST_N low, toggle CLK 5 times -> LED[7:0] = 8'h00 throughout; internal lfsr_0 = 32'h00000001, lfsr_7 = 32'h07070708.
- First edges after release:
  - Edge 1 -> LEDs = 8'h00.
  - Edge 2 -> LEDs = 8'h5D, the parities of seeds 0x00000001, 0x01010102, 0x02020203, 0x03030304, 0x04040405, 0x05050506, 0x06060607, 0x07070708.
- Cell 0 stepping:
  - After edge 1: lfsr_0 = 32'h80200003.
  - After edge 2: acc_0 = 32'h80200004.
  - After edge 3: LED0 = 1.
  - Compare LEDs against a bit-exact reference model for 10000 cycles at a 20 ns period.
- Asynchronous reset mid-run: assert RST_N low between clock edges after 500 cycles -> LEDs go to 8'h00 without waiting for an edge. After release, the LED sequence matches the first-run sequence cycle for cycle.
- Wrap-around: force acc_0 = 32'hFFFFFFFF with lfsr_0 = 32'h00000001 -> next acc_0 = 32'h00000000; the following LED0 = 0.
- Liveness: over 10000 cycles, every LED toggles at least 100 times and no lfsr_i ever equals 0.
